// File: rtl/hdlink_ctrl.sv
// Half-duplex single-wire link controller: sends a command byte on the pad, releases
// the line, then receives the reply byte. Define HDLINK_PARITY_EN to add an even-parity bit in both directions.
module hdlink_ctrl #(
  parameter int BIT_DIV  = 8,
  parameter int TURN_CYC = 2,
  parameter int TIMEOUT  = 16
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_ERR,
  output logic       BUSY,
  output logic       PAD_I,
  output logic       PAD_T,
  input  logic       PAD_O
);

`ifdef HDLINK_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int TX_BITS = 10 + PAR_BITS;
  // Bits sampled after the start bit: data, optional parity, stop.
  localparam int RX_BITS = 9 + PAR_BITS;
  localparam int CNT_MAX = (BIT_DIV > TURN_CYC) ? BIT_DIV : TURN_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT * BIT_DIV + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BIT_DIV / 2 - 1);
  localparam logic [CW-1:0] TURN_END = CW'(TURN_CYC - 1);
  localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT * BIT_DIV - 1);
  localparam logic [3:0]    TX_LAST  = 4'(TX_BITS - 1);
  localparam logic [3:0]    RX_LAST  = 4'(RX_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TX, S_TURN, S_WAIT, S_START_CHK, S_RX, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cyc_q, cyc_d;
  logic [3:0]         bit_q, bit_d;
  logic [TW-1:0]      to_q, to_d;
  logic [TX_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [7:0]         rx_sh_q, rx_sh_d;
  logic               par_q, par_d;
  logic               pad_i_q, pad_i_d, pad_t_q, pad_t_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_err_q, rx_err_d, rx_valid_q, rx_valid_d;
  logic [1:0]         sync_q;
  logic               rx_in;
  logic [TX_BITS-1:0] tx_frame;

`ifdef HDLINK_PARITY_EN
  assign tx_frame = {1'b0, ^TX_DATA, TX_DATA, 1'b1};
`else
  assign tx_frame = {1'b0, TX_DATA, 1'b1};
`endif

  assign rx_in    = sync_q[1];
  assign TX_READY = (state_q == S_IDLE);
  assign BUSY     = (state_q != S_IDLE);
  assign PAD_I    = pad_i_q;
  assign PAD_T    = pad_t_q;
  assign RX_DATA  = rx_data_q;
  assign RX_ERR   = rx_err_q;
  assign RX_VALID = rx_valid_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], PAD_O};
  end

  // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    to_d       = to_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    par_d      = par_q;
    pad_i_d    = pad_i_q;
    pad_t_d    = pad_t_q;
    rx_data_d  = rx_data_q;
    rx_err_d   = rx_err_q;
    rx_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        pad_t_d = 1'b1;
        pad_i_d = 1'b0;
        if (TX_VALID) begin
          state_d = S_TX;
          tx_sh_d = tx_frame;
          pad_t_d = 1'b0;
          pad_i_d = tx_frame[0];
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      S_TX: begin
        if (cyc_q == BIT_END) begin
          cyc_d = '0;
          if (bit_q == TX_LAST) begin
            state_d = S_TURN;
            pad_t_d = 1'b1;
            pad_i_d = 1'b0;
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_sh_d = tx_sh_q >> 1;
            pad_i_d = tx_sh_q[1];
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_TURN: begin
        if (cyc_q == TURN_END) begin
          state_d = S_WAIT;
          cyc_d   = '0;
          to_d    = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (rx_in) begin
          state_d = S_START_CHK;
          cyc_d   = '0;
        end else if (to_q == TO_END) begin
          state_d    = S_DONE;
          rx_data_d  = 8'h00;
          rx_err_d   = 1'b1;
          rx_valid_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_START_CHK: begin
        // A line still high half a bit later is a real start bit; otherwise a glitch.
        if (cyc_q == HALF_END) begin
          cyc_d   = '0;
          bit_d   = '0;
          par_d   = 1'b0;
          state_d = rx_in ? S_RX : S_WAIT;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_RX: begin
        if (cyc_q == BIT_END) begin
          cyc_d = '0;
          if (bit_q == RX_LAST) begin
            state_d    = S_DONE;
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
`ifdef HDLINK_PARITY_EN
            rx_err_d   = rx_in | par_q;
`else
            rx_err_d   = rx_in;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
            par_d = par_q ^ rx_in;
            if (bit_q < 4'd8) rx_sh_d = {rx_in, rx_sh_q[7:1]};
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      to_q       <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      par_q      <= 1'b0;
      pad_i_q    <= 1'b0;
      pad_t_q    <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_err_q   <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      to_q       <= to_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      par_q      <= par_d;
      pad_i_q    <= pad_i_d;
      pad_t_q    <= pad_t_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_hdlink_ctrl.sv
// Self-checking bench for hdlink_ctrl: a pad/responder model drives PAD_O and a
// frame-level reference model supplies every expected value.
module tb_hdlink_ctrl;

  localparam int BD       = 8;
  localparam int TURN     = 2;
  localparam int TOUT     = 16;
`ifdef HDLINK_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 10 + PAR;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY, RX_VALID, RX_ERR, BUSY, PAD_I, PAD_T, PAD_O;
  logic [7:0] RX_DATA;
  logic       ext_drv;

  int total = 0;
  int bad   = 0;

  // Pad model: output buffer wins when enabled, otherwise responder or pulldown.
  assign PAD_O = (PAD_T === 1'b0) ? PAD_I : ext_drv;

  always #5 CLK = ~CLK;

  hdlink_ctrl #(.BIT_DIV(BD), .TURN_CYC(TURN), .TIMEOUT(TOUT)) dut (
    .CLK(CLK), .RSTN(RSTN), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ERR(RX_ERR), .BUSY(BUSY),
    .PAD_I(PAD_I), .PAD_T(PAD_T), .PAD_O(PAD_O)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: line level of TX frame bit k for a command byte.
  function automatic logic exp_tx_bit(input logic [7:0] tx, input int k);
    if (k == 0) return 1'b1;
    if (k <= 8) return tx[k-1];
    if (PAR == 1 && k == 9) return ^tx;
    return 1'b0;
  endfunction

  logic       tx_trace[$];
  int         obs_valid_at, obs_pulses, obs_late_drive;
  logic       obs_ready_after, obs_err;
  logic [7:0] obs_data;

  function automatic int trace_errs(input logic [7:0] tx);
    int e = 0;
    for (int k = 0; k < tx_trace.size(); k++)
      if (tx_trace[k] !== exp_tx_bit(tx, k / BD)) e++;
    return e;
  endfunction

  // Runs one transaction; the responder replies with rb unless resp=0.
  task automatic run_txn(input logic [7:0] tx, input bit resp, input logic [7:0] rb,
                         input bit stop_bad, input bit par_bad, input int gap, input bit glitch);
    logic [10:0] rf;
    int start;
    bit seen;
    tx_trace.delete();
    obs_valid_at = -1; obs_pulses = 0; obs_late_drive = 0;
    obs_ready_after = 1'b0; obs_err = 1'bx; obs_data = 8'hxx;
    rf = '0;
    rf[0] = 1'b1;
    for (int i = 0; i < 8; i++) rf[1+i] = rb[i];
    if (PAR == 1) rf[9] = (^rb) ^ par_bad;
    rf[NB-1] = stop_bad;
    start = glitch ? gap + 12 : gap;
    @(negedge CLK); TX_DATA = tx; TX_VALID = 1'b1;
    @(negedge CLK); TX_VALID = 1'b0;
    while (PAD_T === 1'b0 && tx_trace.size() < 400) begin
      tx_trace.push_back(PAD_I);
      @(negedge CLK);
    end
    seen = 0;
    for (int c = 0; c < 400; c++) begin
      ext_drv = 1'b0;
      if (resp) begin
        if (glitch && c >= gap && c < gap + 2) ext_drv = 1'b1;
        if (c >= start && c < start + NB * BD) ext_drv = rf[(c - start) / BD];
      end
      if (PAD_T !== 1'b1) obs_late_drive++;
      if (RX_VALID === 1'b1) begin
        obs_pulses++;
        if (!seen) begin
          seen = 1; obs_valid_at = c; obs_data = RX_DATA; obs_err = RX_ERR;
        end
      end else if (seen) begin
        obs_ready_after = TX_READY;
        break;
      end
      @(negedge CLK);
    end
    ext_drv = 1'b0;
  endtask

  task automatic test_reset;
    RSTN = 1'b0; TX_VALID = 1'b0; TX_DATA = 8'h00; ext_drv = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if (PAD_T !== 1'b1) begin bad++; $display("FAIL reset_pad_t got=%b exp=1", PAD_T); end
    total++; if (PAD_I !== 1'b0) begin bad++; $display("FAIL reset_pad_i got=%b exp=0", PAD_I); end
    total++; if (TX_READY !== 1'b1 || BUSY !== 1'b0) begin bad++; $display("FAIL reset_ready_busy got=%b%b exp=10", TX_READY, BUSY); end
    total++; if (RX_VALID !== 1'b0 || RX_ERR !== 1'b0 || RX_DATA !== 8'h00) begin
      bad++; $display("FAIL reset_rx got v=%b e=%b d=%h exp v=0 e=0 d=00", RX_VALID, RX_ERR, RX_DATA); end
    RSTN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic;
    run_txn(8'hA5, 1, 8'h3C, 0, 0, 3, 0);
    total++; if (tx_trace.size() != NB * BD) begin bad++; $display("FAIL basic_frame_len got=%0d exp=%0d", tx_trace.size(), NB * BD); end
    total++; if (trace_errs(8'hA5) != 0) begin bad++; $display("FAIL basic_frame_bits got=%0d bad cycles exp=0", trace_errs(8'hA5)); end
    total++; if (obs_data !== 8'h3C) begin bad++; $display("FAIL basic_data got=%h exp=3c", obs_data); end
    total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", obs_err); end
    total++; if (obs_pulses != 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", obs_pulses); end
    total++; if (obs_ready_after !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%b exp=1", obs_ready_after); end
    total++; if (RX_DATA !== 8'h3C) begin bad++; $display("FAIL basic_data_held got=%h exp=3c", RX_DATA); end
  endtask

  task automatic test_timeout;
    run_txn(8'h00, 0, 8'h00, 0, 0, 0, 0);
    total++; if (obs_valid_at != TURN + TOUT * BD) begin
      bad++; $display("FAIL timeout_latency got=%0d exp=%0d", obs_valid_at, TURN + TOUT * BD); end
    total++; if (obs_err !== 1'b1 || obs_data !== 8'h00) begin
      bad++; $display("FAIL timeout_result got e=%b d=%h exp e=1 d=00", obs_err, obs_data); end
    total++; if (obs_late_drive != 0) begin bad++; $display("FAIL timeout_pad_released got=%0d driven cycles exp=0", obs_late_drive); end
    total++; if (obs_pulses != 1) begin bad++; $display("FAIL timeout_pulses got=%0d exp=1", obs_pulses); end
  endtask

  task automatic test_bad_stop;
    run_txn(8'h12, 1, 8'h5A, 1, 0, 5, 0);
    total++; if (obs_err !== 1'b1 || obs_data !== 8'h5A) begin
      bad++; $display("FAIL bad_stop got e=%b d=%h exp e=1 d=5a", obs_err, obs_data); end
  endtask

  task automatic test_glitch;
    run_txn(8'h6E, 1, 8'h81, 0, 0, 4, 1);
    total++; if (obs_err !== 1'b0 || obs_data !== 8'h81) begin
      bad++; $display("FAIL glitch got e=%b d=%h exp e=0 d=81", obs_err, obs_data); end
    total++; if (obs_pulses != 1) begin bad++; $display("FAIL glitch_pulses got=%0d exp=1", obs_pulses); end
  endtask

  task automatic test_reset_mid_frame;
    @(negedge CLK); TX_DATA = 8'hC3; TX_VALID = 1'b1;
    @(negedge CLK); TX_VALID = 1'b0;
    repeat (5 * BD + 3) @(negedge CLK);
    total++; if (PAD_T !== 1'b0) begin bad++; $display("FAIL midrst_driving got=%b exp=0", PAD_T); end
    #2 RSTN = 1'b0;
    #1;
    total++; if (PAD_T !== 1'b1 || PAD_I !== 1'b0) begin
      bad++; $display("FAIL midrst_pad got t=%b i=%b exp t=1 i=0", PAD_T, PAD_I); end
    total++; if (TX_READY !== 1'b1 || BUSY !== 1'b0 || RX_DATA !== 8'h00) begin
      bad++; $display("FAIL midrst_state got r=%b b=%b d=%h exp r=1 b=0 d=00", TX_READY, BUSY, RX_DATA); end
    @(negedge CLK); RSTN = 1'b1;
    @(negedge CLK);
    run_txn(8'h3C, 1, 8'hE7, 0, 0, 6, 0);
    total++; if (trace_errs(8'h3C) != 0 || tx_trace.size() != NB * BD) begin
      bad++; $display("FAIL midrst_frame got len=%0d errs=%0d exp len=%0d errs=0", tx_trace.size(), trace_errs(8'h3C), NB * BD); end
    total++; if (obs_err !== 1'b0 || obs_data !== 8'hE7) begin
      bad++; $display("FAIL midrst_reply got e=%b d=%h exp e=0 d=e7", obs_err, obs_data); end
  endtask

  task automatic test_back_to_back;
    int n, drive;
    drive = 0;
    @(negedge CLK); TX_DATA = 8'h96; TX_VALID = 1'b1;
    @(negedge CLK); TX_DATA = 8'h11;
    n = 0;
    while (RX_VALID !== 1'b1 && n < 1000) begin
      if (PAD_T === 1'b0) drive++;
      n++;
      @(negedge CLK);
    end
    total++; if (drive != NB * BD) begin bad++; $display("FAIL b2b_busy_ignored got=%0d driven cycles exp=%0d", drive, NB * BD); end
    @(negedge CLK);
    total++; if (TX_READY !== 1'b1 || PAD_T !== 1'b1) begin
      bad++; $display("FAIL b2b_ready got r=%b t=%b exp r=1 t=1", TX_READY, PAD_T); end
    @(negedge CLK);
    TX_VALID = 1'b0;
    total++; if (PAD_T !== 1'b0 || PAD_I !== 1'b1 || TX_READY !== 1'b0) begin
      bad++; $display("FAIL b2b_accept got t=%b i=%b r=%b exp t=0 i=1 r=0", PAD_T, PAD_I, TX_READY); end
    repeat (BD) @(negedge CLK);
    total++; if (PAD_I !== 1'b1) begin bad++; $display("FAIL b2b_second_data got=%b exp=1", PAD_I); end
    n = 0;
    while (RX_VALID !== 1'b1 && n < 1000) begin n++; @(negedge CLK); end
    total++; if (RX_VALID !== 1'b1 || RX_ERR !== 1'b1 || RX_DATA !== 8'h00) begin
      bad++; $display("FAIL b2b_second_done got v=%b e=%b d=%h exp v=1 e=1 d=00", RX_VALID, RX_ERR, RX_DATA); end
    @(negedge CLK);
  endtask

  task automatic test_random;
    logic [7:0] tx, rb, exp_d;
    bit resp, sb, pb, gl, exp_e;
    int gap;
    for (int it = 0; it < 10; it++) begin
      tx = 8'($urandom); rb = 8'($urandom);
      resp = ($urandom_range(0, 4) != 0);
      sb = ($urandom_range(0, 3) == 0);
      pb = (PAR == 1) && ($urandom_range(0, 3) == 0);
      gl = ($urandom_range(0, 1) == 1);
      gap = $urandom_range(2, 20);
      run_txn(tx, resp, rb, sb, pb, gap, gl);
      exp_d = resp ? rb : 8'h00;
      exp_e = resp ? (sb | pb) : 1'b1;
      total++; if (trace_errs(tx) != 0 || tx_trace.size() != NB * BD) begin
        bad++; $display("FAIL rand%0d_frame tx=%h got len=%0d errs=%0d exp len=%0d", it, tx, tx_trace.size(), trace_errs(tx), NB * BD); end
      total++; if (obs_data !== exp_d || obs_err !== exp_e) begin
        bad++; $display("FAIL rand%0d_reply got d=%h e=%b exp d=%h e=%b", it, obs_data, obs_err, exp_d, exp_e); end
      total++; if (obs_pulses != 1 || obs_ready_after !== 1'b1 || obs_late_drive != 0) begin
        bad++; $display("FAIL rand%0d_handshake got pulses=%0d ready=%b driven=%0d exp 1 1 0", it, obs_pulses, obs_ready_after, obs_late_drive); end
      if (!resp) begin
        total++; if (obs_valid_at != TURN + TOUT * BD) begin
          bad++; $display("FAIL rand%0d_timeout got=%0d exp=%0d", it, obs_valid_at, TURN + TOUT * BD); end
      end
    end
  endtask

`ifdef HDLINK_PARITY_EN
  task automatic test_parity;
    run_txn(8'h03, 1, 8'h07, 0, 1, 4, 0);
    total++; if (tx_trace.size() != NB * BD || tx_trace[9 * BD + BD / 2] !== 1'b0) begin
      bad++; $display("FAIL parity_tx got len=%0d exp len=%0d with parity bit 0", tx_trace.size(), NB * BD); end
    total++; if (obs_err !== 1'b1 || obs_data !== 8'h07) begin
      bad++; $display("FAIL parity_rx got e=%b d=%h exp e=1 d=07", obs_err, obs_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_bad_stop();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef HDLINK_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdlink_ctrl.md
# hdlink_ctrl

Half-duplex single-wire link controller that drives the I/T pins and samples the O pin of a bidirectional pulldown pad. It is the core-side end of the pad interface. For each command it serializes a byte onto the pad, releases the line, and deserializes the responder's reply byte. The pad's pulldown defines the idle-low line. The block sits between a byte-wide request/response port in the fabric and one bidirectional pad instance.

## Interface
Parameters:
- BIT_DIV, 8: clock cycles per bit period; even, minimum 4.
- TURN_CYC, 2: cycles the line is released and ignored after the TX stop bit.
- TIMEOUT, 16: bit periods to wait for the reply start bit.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- TX_DATA  in  8  command byte, LSB first on the line.
- TX_VALID  in  1  request; accepted when TX_VALID && TX_READY at a rising edge.
- TX_READY  out  1  high only in IDLE.
- RX_DATA  out  8  reply byte; held until the next RX_VALID.
- RX_VALID  out  1  one-cycle pulse at transaction end.
- RX_ERR  out  1  qualified by RX_VALID: timeout, bad stop bit, or parity error.
- BUSY  out  1  high from accept until after the RX_VALID pulse.
- PAD_I  out  1  data to the pad output buffer.
- PAD_T  out  1  pad tristate control; 1 = released (pad not driving), 0 = driving.
- PAD_O  in  1  pad input buffer; asynchronous to CLK.

## Operation
- PAD_O passes through a 2-flop synchronizer (reset 0). All RX decisions use the synchronized value.
- States: IDLE, TX, TURN, WAIT, START_CHK, RX, DONE.
- IDLE: PAD_T=1, PAD_I=0. On accept, latch TX_DATA and go to TX.
- TX:
  - PAD_T=0.
  - Frame is start bit (1), 8 data bits LSB first, optional parity bit, stop bit (0).
  - Each bit is held BIT_DIV cycles. After the last stop-bit cycle, go to TURN.
- TURN: PAD_T=1, PAD_I=0. Input ignored for TURN_CYC cycles, then go to WAIT.
- WAIT:
  - Timeout counter runs from 0.
  - Synchronized input = 1 → START_CHK.
  - Counter reaches TIMEOUT*BIT_DIV → DONE with RX_ERR=1 and RX_DATA=0x00.
- START_CHK:
  - Wait BIT_DIV/2 cycles, then resample.
  - If still 1, go to RX.
  - If 0, treat as a glitch and return to WAIT. The timeout counter is not reset.
- RX:
  - Sample at each subsequent bit center (every BIT_DIV cycles): 8 data bits, optional parity, stop.
  - Stop sample must be 0, else RX_ERR=1. RX_DATA still updates with the sampled byte.
  - Then go to DONE.
- DONE: RX_VALID=1 for one cycle, then IDLE.
- TX_VALID outside IDLE is ignored and not queued.
- RSTN low at any time forces IDLE immediately (asynchronous), including mid-frame. PAD_T=1 takes effect without waiting for a clock.
- Reset values:
  - PAD_T=1, PAD_I=0.
  - TX_READY=1, BUSY=0.
  - RX_VALID=0, RX_ERR=0, RX_DATA=0x00.
  - Synchronizer flops 0; all counters 0.

## Timing
- PAD_T/PAD_I are registered. The start bit appears on the cycle after accept.
- TX frame is 10*BIT_DIV cycles (11*BIT_DIV with parity).
- PAD_T rises exactly one cycle after the final stop-bit cycle. The pad is never driven during TURN, WAIT, START_CHK or RX.
- Reply start detection lags the pad edge by 2 cycles (synchronizer).
- RX_DATA and RX_ERR update on the same edge that asserts RX_VALID.
- TX_READY rises on the cycle after the RX_VALID pulse. Back-to-back accept is allowed that cycle.
- With no response, the transaction length is 1 + TX frame + TURN_CYC + TIMEOUT*BIT_DIV + 1 cycles.

## Configuration
- HDLINK_PARITY_EN defined:
  - An even-parity bit follows the data bits in both directions.
  - TX computes it from TX_DATA.
  - RX parity mismatch sets RX_ERR=1; RX_DATA still updates.
- HDLINK_PARITY_EN undefined: no parity bit in either direction; frames are 10 bits.

## Test plan
All scenarios use BIT_DIV=8, TURN_CYC=2, TIMEOUT=16.
- Send 0xA5; responder model replies 0x3C → PAD_I bit sequence 1,1,0,1,0,0,1,0,1,0, 8 cycles each. Then RX_DATA=0x3C, one RX_VALID pulse, RX_ERR=0.
- Send 0x00; no reply → RX_VALID with RX_ERR=1 and RX_DATA=0x00 exactly 128 cycles after entering WAIT. PAD_T stays 1 throughout.
- Reply 0x5A with stop bit driven 1 → RX_VALID, RX_ERR=1, RX_DATA=0x5A.
- 2-cycle high glitch on PAD_O in WAIT, then valid reply 0x81 → glitch rejected; RX_DATA=0x81, RX_ERR=0.
- RSTN low during TX data bit 4 → PAD_T=1 and PAD_I=0 before the next CLK edge. After release, TX_READY=1, and a new 0x3C transaction completes correctly.
- With HDLINK_PARITY_EN, reply 0x07 with parity bit 0 → RX_ERR=1, RX_DATA=0x07. TX of 0x03 emits parity bit 0.
